// File: rtl/cache_line_mover.sv
// cache_line_mover: moves one cache line between the 4-way data RAM and the memory bus.
// An optional dirty-victim writeback (RAM -> bus) runs first, then the fill (bus -> RAM).
module cache_line_mover #(
    parameter int unsigned LINE_WORDS = 16,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rest,
    input  logic        start,
    input  logic        wbEnable,
    input  logic [31:0] wbAddress,
    input  logic [31:0] fillAddress,
    input  logic [1:0]  way,
    output logic        busy,
    output logic        done,
    output logic [31:0] ram_readAddress,
    output logic [1:0]  ram_readWay,
    input  logic [31:0] ram_readData,
    output logic [31:0] ram_writeAddress,
    output logic [1:0]  ram_writeWay,
    output logic [31:0] ram_writeData,
    output logic        ram_writeEnable,
    output logic [3:0]  ram_writeByteEnable,
    output logic [31:0] m0_address,
    output logic [3:0]  m0_byteEnable,
    output logic        m0_read,
    input  logic [31:0] m0_readData,
    output logic        m0_write,
    output logic [31:0] m0_writeData,
    input  logic        m0_waitRequest,
    input  logic        m0_readDataValid
);

    localparam int unsigned IDX_W      = $clog2(LINE_WORDS);
    localparam int unsigned CNT_W      = IDX_W + 1;
    localparam int unsigned LINE_BYTES = LINE_WORDS * 4;
    localparam logic [31:0]      OFS_MASK = 32'(LINE_BYTES - 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LINE_WORDS);

    // Reject line sizes that are not a power of two or do not fit in one RAM way.
    if ((LINE_WORDS < 2) || ((LINE_WORDS & (LINE_WORDS - 1)) != 0) ||
        (ADDR_WIDTH < IDX_W + 2)) begin : g_param_check
        $error("cache_line_mover: LINE_WORDS must be a power of two that fits in ADDR_WIDTH");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB_RD,
        S_WB_WR,
        S_FILL,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       way_q, way_d;
    logic [31:0]      wb_base_q, wb_base_d;
    logic [31:0]      fill_base_q, fill_base_d;
    logic [CNT_W-1:0] wb_idx_q, wb_idx_d;
    logic [CNT_W-1:0] issue_idx_q, issue_idx_d;
    logic [CNT_W-1:0] rx_idx_q, rx_idx_d;
    logic [31:0]      hold_q, hold_d;
    logic             wb_first_q, wb_first_d;

    logic wr_accept;
    logic rd_accept;
    logic rx_fire;

    // Word byte address inside a line; the offset bits of the base are discarded.
    function automatic logic [31:0] line_addr(input logic [31:0] base,
                                              input logic [IDX_W-1:0] idx);
        line_addr = (base & ~OFS_MASK) | 32'({idx, 2'b00});
    endfunction

    // Bus handshakes and fill-return qualification.
    assign m0_write  = (state_q == S_WB_WR);
    assign m0_read   = (state_q == S_FILL) && (issue_idx_q < FULL_CNT);
    assign wr_accept = m0_write && !m0_waitRequest;
    assign rd_accept = m0_read && !m0_waitRequest;
    assign rx_fire   = (state_q == S_FILL) && m0_readDataValid && (rx_idx_q < FULL_CNT);

    // Bus address: victim word during writeback, next issue word during fill.
    assign m0_address    = m0_write ? line_addr(wb_base_q, wb_idx_q[IDX_W-1:0]) :
                           (state_q == S_FILL) ? line_addr(fill_base_q, issue_idx_q[IDX_W-1:0]) :
                           32'd0;
    // RAM data is only valid in the first WB_WR cycle; later stall cycles replay the holding copy.
    assign m0_writeData  = !m0_write ? 32'd0 : (wb_first_q ? ram_readData : hold_q);
    assign m0_byteEnable = 4'hF;

    assign ram_readAddress     = line_addr(wb_base_q, wb_idx_q[IDX_W-1:0]);
    assign ram_readWay         = way_q;
    assign ram_writeAddress    = line_addr(fill_base_q, rx_idx_q[IDX_W-1:0]);
    assign ram_writeWay        = way_q;
    assign ram_writeData       = m0_readData;
    assign ram_writeEnable     = rx_fire;
    assign ram_writeByteEnable = 4'hF;

    assign busy = (state_q == S_WB_RD) || (state_q == S_WB_WR) || (state_q == S_FILL);
    assign done = (state_q == S_DONE);

    // Next-state logic for the transfer sequence.
    always_comb begin
        state_d     = state_q;
        way_d       = way_q;
        wb_base_d   = wb_base_q;
        fill_base_d = fill_base_q;
        wb_idx_d    = wb_idx_q;
        issue_idx_d = issue_idx_q;
        rx_idx_d    = rx_idx_q;
        hold_d      = hold_q;
        wb_first_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    way_d       = way;
                    wb_base_d   = wbAddress;
                    fill_base_d = fillAddress;
                    wb_idx_d    = '0;
                    issue_idx_d = '0;
                    rx_idx_d    = '0;
                    state_d     = wbEnable ? S_WB_RD : S_FILL;
                end
            end
            S_WB_RD: begin
                wb_first_d = 1'b1;
                state_d    = S_WB_WR;
            end
            S_WB_WR: begin
                if (wb_first_q) begin
                    hold_d = ram_readData;
                end
                if (wr_accept) begin
                    if (wb_idx_q == LAST_IDX) begin
                        issue_idx_d = '0;
                        rx_idx_d    = '0;
                        state_d     = S_FILL;
                    end else begin
                        wb_idx_d = wb_idx_q + CNT_W'(1);
                        state_d  = S_WB_RD;
                    end
                end
            end
            S_FILL: begin
                if (rd_accept) begin
                    issue_idx_d = issue_idx_q + CNT_W'(1);
                end
                if (rx_fire) begin
                    rx_idx_d = rx_idx_q + CNT_W'(1);
                    if (rx_idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rest) begin
            state_q     <= S_IDLE;
            way_q       <= '0;
            wb_base_q   <= '0;
            fill_base_q <= '0;
            wb_idx_q    <= '0;
            issue_idx_q <= '0;
            rx_idx_q    <= '0;
            hold_q      <= '0;
            wb_first_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            way_q       <= way_d;
            wb_base_q   <= wb_base_d;
            fill_base_q <= fill_base_d;
            wb_idx_q    <= wb_idx_d;
            issue_idx_q <= issue_idx_d;
            rx_idx_q    <= rx_idx_d;
            hold_q      <= hold_d;
            wb_first_q  <= wb_first_d;
        end
    end

endmodule

// File: tb/tb_cache_line_mover.sv
// Bench for cache_line_mover: data RAM and bus slave models with a scoreboard of expected transfers.
module tb_cache_line_mover;

    logic        clk = 1'b0;
    logic        rest;
    logic        start;
    logic        wbEnable;
    logic [31:0] wbAddress;
    logic [31:0] fillAddress;
    logic [1:0]  way;
    logic        busy;
    logic        done;
    logic [31:0] ram_readAddress;
    logic [1:0]  ram_readWay;
    logic [31:0] ram_readData;
    logic [31:0] ram_writeAddress;
    logic [1:0]  ram_writeWay;
    logic [31:0] ram_writeData;
    logic        ram_writeEnable;
    logic [3:0]  ram_writeByteEnable;
    logic [31:0] m0_address;
    logic [3:0]  m0_byteEnable;
    logic        m0_read;
    logic [31:0] m0_readData;
    logic        m0_write;
    logic [31:0] m0_writeData;
    logic        m0_waitRequest;
    logic        m0_readDataValid;

    cache_line_mover #(.LINE_WORDS(16), .ADDR_WIDTH(10)) dut (
        .clk                 (clk),
        .rest                (rest),
        .start               (start),
        .wbEnable            (wbEnable),
        .wbAddress           (wbAddress),
        .fillAddress         (fillAddress),
        .way                 (way),
        .busy                (busy),
        .done                (done),
        .ram_readAddress     (ram_readAddress),
        .ram_readWay         (ram_readWay),
        .ram_readData        (ram_readData),
        .ram_writeAddress    (ram_writeAddress),
        .ram_writeWay        (ram_writeWay),
        .ram_writeData       (ram_writeData),
        .ram_writeEnable     (ram_writeEnable),
        .ram_writeByteEnable (ram_writeByteEnable),
        .m0_address          (m0_address),
        .m0_byteEnable       (m0_byteEnable),
        .m0_read             (m0_read),
        .m0_readData         (m0_readData),
        .m0_write            (m0_write),
        .m0_writeData        (m0_writeData),
        .m0_waitRequest      (m0_waitRequest),
        .m0_readDataValid    (m0_readDataValid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Single comparison point: counts and reports.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Models and scoreboard state.
    typedef struct {
        int          due;
        logic [31:0] data;
    } ret_t;

    logic [31:0] ram [4][256];
    logic [31:0] exp_wr_addr[$];
    logic [31:0] exp_wr_data[$];
    logic [31:0] exp_rd_addr[$];
    logic [1:0]  exp_ram_way[$];
    logic [31:0] exp_ram_addr[$];
    logic [31:0] exp_ram_data[$];
    ret_t        pend[$];

    int          cyc = 0;
    int          wr_stall_left = 0;
    int          rd_stall_left = 0;
    logic [31:0] rd_base = 32'd0;
    logic [7:0]  rd_idx_s = 8'd0;
    logic [1:0]  rd_way_s = 2'd0;
    logic        hold_wr = 1'b0;
    logic        hold_rd = 1'b0;
    logic [31:0] hold_addr = 32'd0;
    logic [31:0] hold_data = 32'd0;

    // Drive slave/RAM responses shortly after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        ram_readData = ram[rd_way_s][rd_idx_s];
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            m0_readDataValid = 1'b1;
            m0_readData      = pend[0].data;
            void'(pend.pop_front());
        end else begin
            m0_readDataValid = 1'b0;
            m0_readData      = 32'd0;
        end
        m0_waitRequest = 1'b0;
        if (m0_write && m0_address[5:2] == 4'd5 && wr_stall_left > 0) begin
            m0_waitRequest = 1'b1;
            wr_stall_left--;
        end
        if (m0_read && m0_address[5:2] == 4'd9 && rd_stall_left > 0) begin
            m0_waitRequest = 1'b1;
            rd_stall_left--;
        end
    end

    // Monitor on the falling edge: handshakes, held requests, RAM writes.
    always @(negedge clk) begin
        rd_idx_s = ram_readAddress[9:2];
        rd_way_s = ram_readWay;
        if (hold_wr) begin
            check("wr_hold_req", 64'(m0_write), 1);
            check("wr_hold_addr", 64'(m0_address), 64'(hold_addr));
            check("wr_hold_data", 64'(m0_writeData), 64'(hold_data));
        end
        if (hold_rd) begin
            check("rd_hold_req", 64'(m0_read), 1);
            check("rd_hold_addr", 64'(m0_address), 64'(hold_addr));
        end
        hold_wr   = m0_write && m0_waitRequest;
        hold_rd   = m0_read && m0_waitRequest;
        hold_addr = m0_address;
        hold_data = m0_writeData;
        if (m0_read || m0_write) begin
            check("rw_exclusive", 64'(m0_read && m0_write), 0);
            check("m0_byteEnable", 64'(m0_byteEnable), 64'hF);
        end
        if (m0_write && !m0_waitRequest) begin
            if (exp_wr_addr.size() == 0) begin
                check("wr_unexpected", 64'(m0_address), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("wr_addr", 64'(m0_address), 64'(exp_wr_addr.pop_front()));
                check("wr_data", 64'(m0_writeData), 64'(exp_wr_data.pop_front()));
            end
        end
        if (m0_read && !m0_waitRequest) begin
            check("rd_before_wb_done", 64'(exp_wr_addr.size()), 0);
            if (exp_rd_addr.size() == 0) begin
                check("rd_unexpected", 64'(m0_address), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("rd_addr", 64'(m0_address), 64'(exp_rd_addr.pop_front()));
            end
            pend.push_back('{cyc + 2, rd_base + 32'(m0_address[5:2])});
        end
        if (ram_writeEnable) begin
            if (exp_ram_addr.size() == 0) begin
                check("ram_wr_unexpected", 64'(ram_writeAddress), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("ram_wr_way", 64'(ram_writeWay), 64'(exp_ram_way.pop_front()));
                check("ram_wr_addr", 64'(ram_writeAddress), 64'(exp_ram_addr.pop_front()));
                check("ram_wr_data", 64'(ram_writeData), 64'(exp_ram_data.pop_front()));
                check("ram_wr_be", 64'(ram_writeByteEnable), 64'hF);
            end
            ram[ram_writeWay][ram_writeAddress[9:2]] = ram_writeData;
        end
    end

    task automatic clear_expect();
        exp_wr_addr.delete();
        exp_wr_data.delete();
        exp_rd_addr.delete();
        exp_ram_way.delete();
        exp_ram_addr.delete();
        exp_ram_data.delete();
    endtask

    // Queue the expected transfers of one miss.
    task automatic push_expect(input logic wb_en, input logic [31:0] wba, input logic [31:0] fa,
                               input logic [1:0] w, input logic [31:0] rbase);
        logic [31:0] wb_b;
        logic [31:0] f_b;
        wb_b = wba & ~32'h3F;
        f_b  = fa & ~32'h3F;
        for (int i = 0; i < 16; i++) begin
            if (wb_en) begin
                exp_wr_addr.push_back(wb_b + 32'(i * 4));
                exp_wr_data.push_back(ram[w][wb_b[9:2] + 8'(i)]);
            end
            exp_rd_addr.push_back(f_b + 32'(i * 4));
            exp_ram_way.push_back(w);
            exp_ram_addr.push_back(f_b + 32'(i * 4));
            exp_ram_data.push_back(rbase + 32'(i));
        end
    endtask

    // One complete miss; mid_start >= 0 fires a second start that many cycles in.
    task automatic run_op(input logic wb_en, input logic [31:0] wba, input logic [31:0] fa,
                          input logic [1:0] w, input logic [31:0] rbase, input int mid_start);
        bit finished;
        int tail;
        finished = 1'b0;
        tail     = (mid_start >= 0) ? 30 : 2;
        rd_base  = rbase;
        push_expect(wb_en, wba, fa, w, rbase);
        @(negedge clk);
        check("busy_before_start", 64'(busy), 0);
        start       = 1'b1;
        wbEnable    = wb_en;
        wbAddress   = wba;
        fillAddress = fa;
        way         = w;
        @(negedge clk);
        start       = 1'b0;
        wbEnable    = 1'b0;
        wbAddress   = 32'd0;
        fillAddress = 32'd0;
        way         = 2'd0;
        for (int c = 0; c < 400 && !finished; c++) begin
            if (c == mid_start) begin
                start       = 1'b1;
                wbEnable    = 1'b1;
                wbAddress   = 32'h7000;
                fillAddress = 32'h7400;
                way         = 2'd3;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                finished = 1'b1;
                check("busy_at_done", 64'(busy), 0);
                check("ram_left_at_done", 64'(exp_ram_addr.size()), 0);
            end else begin
                check("busy_running", 64'(busy), 1);
                @(negedge clk);
            end
        end
        start = 1'b0;
        check("done_seen", 64'(finished), 1);
        for (int k = 0; k < tail; k++) begin
            @(negedge clk);
            check("done_single", 64'(done), 0);
            check("busy_after_done", 64'(busy), 0);
        end
        check("wr_left", 64'(exp_wr_addr.size()), 0);
        check("rd_left", 64'(exp_rd_addr.size()), 0);
        check("ram_left", 64'(exp_ram_addr.size()), 0);
        clear_expect();
    endtask

    // Fill interrupted by a one-cycle reset after the 7th RAM write.
    task automatic run_reset_mid();
        int  nwr;
        bit  hit;
        nwr     = 0;
        hit     = 1'b0;
        rd_base = 32'h50;
        push_expect(1'b0, 32'd0, 32'h4000, 2'd0, 32'h50);
        @(negedge clk);
        start       = 1'b1;
        wbEnable    = 1'b0;
        wbAddress   = 32'd0;
        fillAddress = 32'h4000;
        way         = 2'd0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            if (ram_writeEnable) nwr++;
            if (nwr == 7) hit = 1'b1;
            else @(negedge clk);
        end
        check("rst_reached_7", 64'(hit), 1);
        rest = 1'b1;
        @(posedge clk);
        #3;
        clear_expect();
        @(negedge clk);
        rest = 1'b0;
        check("rst_busy", 64'(busy), 0);
        check("rst_m0_read", 64'(m0_read), 0);
        check("rst_m0_write", 64'(m0_write), 0);
        check("rst_done", 64'(done), 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("late_rdv_no_write", 64'(ram_writeEnable), 0);
            check("late_busy", 64'(busy), 0);
        end
        check("pending_drained", 64'(pend.size()), 0);
    endtask

    initial begin
        rest             = 1'b1;
        start            = 1'b0;
        wbEnable         = 1'b0;
        wbAddress        = 32'd0;
        fillAddress      = 32'd0;
        way              = 2'd0;
        m0_waitRequest   = 1'b0;
        m0_readDataValid = 1'b0;
        m0_readData      = 32'd0;
        ram_readData     = 32'd0;
        for (int w = 0; w < 4; w++) begin
            for (int a = 0; a < 256; a++) ram[w][a] = 32'd0;
        end
        for (int i = 0; i < 16; i++) begin
            ram[1][i] = 32'hB0 + 32'(i);
            ram[3][i] = 32'h300 + 32'(i);
        end

        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 0);
        check("reset_done", 64'(done), 0);
        check("reset_m0_read", 64'(m0_read), 0);
        check("reset_m0_write", 64'(m0_write), 0);
        check("reset_ram_we", 64'(ram_writeEnable), 0);
        rest = 1'b0;

        // Clean fill, way 2.
        run_op(1'b0, 32'd0, 32'h1040, 2'd2, 32'hA0, -1);
        // Writeback of way 1 victim, then fill.
        run_op(1'b1, 32'h2000, 32'h3000, 2'd1, 32'hC0, -1);
        // Stalls on write word 5 and read issue 9.
        wr_stall_left = 3;
        rd_stall_left = 3;
        run_op(1'b1, 32'h2000, 32'h3040, 2'd1, 32'hD0, -1);
        check("wr_stall_used", 64'(wr_stall_left), 0);
        check("rd_stall_used", 64'(rd_stall_left), 0);
        // Unaligned bases.
        run_op(1'b0, 32'd0, 32'h1057, 2'd0, 32'hE0, -1);
        run_op(1'b1, 32'h2013, 32'h1057, 2'd3, 32'h70, -1);
        // Second start while busy is ignored.
        run_op(1'b0, 32'd0, 32'h5000, 2'd2, 32'hF0, 5);
        // Reset mid-fill, then a normal miss.
        run_reset_mid();
        run_op(1'b0, 32'd0, 32'h6000, 2'd0, 32'h60, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cache_line_mover.md
Name: cache_line_mover

Overview:
- Line-transfer engine sitting directly below the cache read/write datapath, between the 4-way data RAM and the memory bus master port.
- On a miss the cache controller hands it a victim line and a fill line. It optionally writes the 16-word dirty victim back to memory, then fetches the 16-word fill line and writes it into the selected way.
- Signals done when the new line is resident so the controller can update the tag RAM and retry the access.

Parameters:
- LINE_WORDS, 16, words per cache line (64-byte line); must be a power of two.
- ADDR_WIDTH, 10, byte-address width of one way of the data RAM; RAM addresses are driven as full 32-bit byte addresses and the RAM uses bits [ADDR_WIDTH-1:2].

Ports:
- clk  in  1  clock
- rest  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request strobe, sampled only in IDLE
- wbEnable  in  1  victim is dirty, perform writeback first
- wbAddress  in  32  victim line byte address; bits [5:0] ignored
- fillAddress  in  32  fill line byte address; bits [5:0] ignored
- way  in  2  target way for both victim read and fill write
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle completion pulse
- ram_readAddress  out  32  data RAM read byte address
- ram_readWay  out  2  data RAM read way
- ram_readData  in  32  read data, valid 1 cycle after address
- ram_writeAddress  out  32  data RAM write byte address
- ram_writeWay  out  2  data RAM write way
- ram_writeData  out  32  data RAM write data
- ram_writeEnable  out  1  data RAM write strobe
- ram_writeByteEnable  out  4  always 4'hF when writing
- m0_address  out  32  memory byte address, word-aligned
- m0_byteEnable  out  4  always 4'hF
- m0_read  out  1  read request
- m0_readData  in  32  read return data
- m0_write  out  1  write request
- m0_writeData  out  32  write data
- m0_waitRequest  in  1  slave stall; a request is accepted in a cycle where it is high and waitRequest is low
- m0_readDataValid  in  1  read data return strobe; in-order, pipelined

Behaviour:
- Reset: state IDLE, all counters 0, busy=0, done=0, m0_read=0, m0_write=0, ram_writeEnable=0. Other outputs are don't-care but driven to 0.
- Line address base: {addr[31:6], idx[3:0], 2'b00}.
- Inputs are latched on the accepted start: way, both bases and wbEnable.
- IDLE:
  - start=1 with wbEnable=1 -> WB_RD, wbIdx=0.
  - start=1 with wbEnable=0 -> FILL, issueIdx=0, rxIdx=0.
- WB_RD (1 cycle):
  - Drive ram_readAddress = victim base + wbIdx*4, ram_readWay = way.
  - Next state WB_WR.
- WB_WR:
  - The first cycle captures ram_readData into a holding register.
  - m0_write=1 with m0_address = victim base + wbIdx*4 and m0_writeData = holding register.
  - m0_write and m0_writeData are held stable while m0_waitRequest=1.
  - On accept: if wbIdx = LINE_WORDS-1 -> FILL (counters cleared); else wbIdx+1 -> WB_RD.
  - Cost is 2 cycles per word minimum.
- FILL:
  - m0_read=1 with m0_address = fill base + issueIdx*4 while issueIdx < LINE_WORDS.
  - issueIdx increments on each accept; m0_read drops the cycle after the 16th accept.
  - Each m0_readDataValid writes the data RAM in the same cycle:
    - ram_writeEnable=1, ram_writeAddress = fill base + rxIdx*4, ram_writeWay = way, ram_writeData = m0_readData.
    - rxIdx then increments.
  - Issue and return overlap.
  - When the 16th return is written -> DONE.
- DONE: done=1 for one cycle, busy=0, -> IDLE.
- busy is high in WB_RD, WB_WR and FILL.
- m0_read and m0_write are never high together.
- start outside IDLE is ignored.
- m0_readDataValid outside FILL is ignored and produces no RAM write.
- Counters are log2(LINE_WORDS)+1 bits wide; there is no wrap-around into the next line.
- Reset mid-operation returns to IDLE the next cycle and drops all strobes. Returns still in flight are ignored, and the tag is not updated by this block.

Test Plan:
- Clean fill: start, wbEnable=0, fillAddress=0x00001040, way=2, waitRequest=0, data returned with 2-cycle latency as 0xA0+idx -> 16 reads at 0x1040..0x107C, RAM writes of way 2 with data 0xA0..0xAF, done pulses once; busy is high from the cycle after start until done.
- Writeback then fill: wbEnable=1, wbAddress=0x2000, RAM way 1 preloaded with 0xB0+idx -> 16 writes 0x2000..0x203C with data 0xB0..0xBF in order, then 16 reads from the fill line; no read is issued before the last write is accepted.
- Stall: waitRequest high for 3 cycles on write word 5 and on read issue 9 -> m0_address/m0_writeData held stable; the word is not duplicated or skipped; done is asserted exactly after 16 RAM writes.
- Unaligned bases: fillAddress=0x1057 -> first m0_address=0x1040.
- Start while busy: a second start mid-FILL -> ignored, single done.
- Reset during FILL after 7 returns: rest for 1 cycle -> IDLE, m0_read=0; late readDataValid pulses produce no RAM writes; a new start completes normally.
